// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths and the writeback source encoding
// used by the register-file write-port arbiter.
package cpu_pkg;

    localparam int XLEN    = 32;
    localparam int REG_AW  = 5;
    localparam int NUM_WB  = 3;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_LSU = 2'd1,
        WB_MDU = 2'd2
    } wb_src_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found at or
// after ptr, wrapping modulo N. Produces a one-hot grant and its index.
module rr_arbiter #(
    parameter int N    = 3,
    parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_idx
);

    // cand_idx[gi] is the requester examined at search position gi
    logic [ID_W-1:0] cand_idx [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cand
            logic [ID_W:0] sum;
            assign sum           = {1'b0, ptr} + (ID_W+1)'(gi);
            assign cand_idx[gi]  = (sum >= (ID_W+1)'(N)) ? ID_W'(sum - (ID_W+1)'(N))
                                                         : ID_W'(sum);
        end
    endgenerate

    always_comb begin
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[cand_idx[k]]) begin
                found             = 1'b1;
                gnt_idx           = cand_idx[k];
                gnt[cand_idx[k]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between NUM_REQ writeback producers.
// Round-robin grant, one registered write per cycle, x0 writes are swallowed.
module regfile_wb_arbiter
    import cpu_pkg::*;
#(
    parameter int NUM_REQ = cpu_pkg::NUM_WB,
    parameter int XLEN    = cpu_pkg::XLEN,
    parameter int REG_AW  = cpu_pkg::REG_AW,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*REG_AW-1:0] req_rd,
    input  logic [NUM_REQ*XLEN-1:0]   req_data,
    output logic                      wb_we,
    output logic [REG_AW-1:0]         wb_addr,
    output logic [XLEN-1:0]           wb_data,
    output logic [ID_W-1:0]           wb_src,
    output logic                      conflict
);

    logic [ID_W-1:0]    rr_ptr_reg;
    logic [ID_W-1:0]    rr_ptr_next;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_any;

    logic [REG_AW-1:0]  rd_arr   [NUM_REQ];
    logic [XLEN-1:0]    data_arr [NUM_REQ];

    logic               wb_we_reg;
    logic [REG_AW-1:0]  wb_addr_reg;
    logic [XLEN-1:0]    wb_data_reg;
    logic [ID_W-1:0]    wb_src_reg;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign rd_arr[gi]   = req_rd[gi*REG_AW +: REG_AW];
            assign data_arr[gi] = req_data[gi*XLEN +: XLEN];
        end
    endgenerate

    rr_arbiter #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_rr_arbiter (
        .req     (req_valid),
        .ptr     (rr_ptr_reg),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Nothing is accepted while reset is held; requesters re-present afterwards
    assign req_ready = rst ? '0 : gnt;
    assign gnt_any   = |req_ready;
    assign conflict  = $countones(req_valid) > 1;

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (gnt_any) begin
            rr_ptr_next = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + ID_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg  <= '0;
            wb_we_reg   <= 1'b0;
            wb_addr_reg <= '0;
            wb_data_reg <= '0;
            wb_src_reg  <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
            if (gnt_any) begin
                wb_we_reg   <= (rd_arr[gnt_idx] != '0);
                wb_addr_reg <= rd_arr[gnt_idx];
                wb_data_reg <= data_arr[gnt_idx];
                wb_src_reg  <= gnt_idx;
            end else begin
                wb_we_reg   <= 1'b0;
            end
        end
    end

    assign wb_we   = wb_we_reg;
    assign wb_addr = wb_addr_reg;
    assign wb_data = wb_data_reg;
    assign wb_src  = wb_src_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, round robin, x0 writes,
// pointer hold across idle cycles and reset while a write is in flight.
module tb_regfile_wb_arbiter;
    import cpu_pkg::*;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int XW = 32;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_rd;
    logic [N*XW-1:0] req_data;
    logic            wb_we;
    logic [AW-1:0]   wb_addr;
    logic [XW-1:0]   wb_data;
    logic [IW-1:0]   wb_src;
    logic            conflict;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .NUM_REQ (N),
        .XLEN    (XW),
        .REG_AW  (AW),
        .ID_W    (IW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rd    (req_rd),
        .req_data  (req_data),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .wb_src    (wb_src),
        .conflict  (conflict)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] rd, input logic [XW-1:0] d);
        req_rd[i*AW +: AW]   = rd;
        req_data[i*XW +: XW] = d;
    endtask

    // Inputs are already applied; check ready/conflict mid-cycle, then the
    // registered write one edge later.
    task automatic cycle(input string tag, input logic [N-1:0] exp_ready,
                         input logic exp_conf, input logic exp_we,
                         input logic [AW-1:0] exp_addr, input logic [XW-1:0] exp_data,
                         input logic [IW-1:0] exp_src);
        @(negedge clk);
        check({tag, ".ready"}, 64'(req_ready), 64'(exp_ready));
        check({tag, ".conflict"}, 64'(conflict), 64'(exp_conf));
        @(posedge clk);
        #1;
        check({tag, ".we"}, 64'(wb_we), 64'(exp_we));
        check({tag, ".addr"}, 64'(wb_addr), 64'(exp_addr));
        check({tag, ".data"}, 64'(wb_data), 64'(exp_data));
        check({tag, ".src"}, 64'(wb_src), 64'(exp_src));
        $display("%-8s valid=%b ready=%b we=%b addr=%0d data=%h src=%0d",
                 tag, req_valid, exp_ready, wb_we, wb_addr, wb_data, wb_src);
    endtask

    initial begin
        logic [XW-1:0] rr_data [N];
        rr_data[0] = 32'hA000_0000;
        rr_data[1] = 32'hA111_1111;
        rr_data[2] = 32'hA222_2222;

        // Reset held two cycles with every requester valid
        rst       = 1'b1;
        req_valid = 3'b111;
        req_rd    = '0;
        req_data  = '0;
        for (int i = 0; i < N; i++) set_req(i, AW'(i + 1), rr_data[i]);
        @(posedge clk);
        #1;
        cycle("reset", 3'b000, 1'b1, 1'b0, 5'd0, 32'h0, 2'd0);

        // Round robin from rr_ptr=0: 0,1,2,0,1,2
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle("rr", 3'(1 << (i % 3)), 1'b1, 1'b1, AW'((i % 3) + 1),
                  rr_data[i % 3], IW'(i % 3));
        end

        // Single requester (load unit)
        req_valid = 3'b010;
        set_req(int'(WB_LSU), 5'd7, 32'hDEAD_BEEF);
        cycle("single", 3'b010, 1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF, 2'd1);

        // x0 write from requester 2: accepted, never written
        req_valid = 3'b100;
        set_req(int'(WB_MDU), 5'd0, 32'h1234_5678);
        cycle("x0", 3'b100, 1'b0, 1'b0, 5'd0, 32'h1234_5678, 2'd2);

        // Idle cycles: wb_we low, other outputs hold
        req_valid = 3'b000;
        cycle("idle0", 3'b000, 1'b0, 1'b0, 5'd0, 32'h1234_5678, 2'd2);
        cycle("idle1", 3'b000, 1'b0, 1'b0, 5'd0, 32'h1234_5678, 2'd2);

        // Pointer wrapped to 0 after the grant to 2
        req_valid = 3'b101;
        set_req(0, 5'd9, 32'h0000_0099);
        set_req(2, 5'd10, 32'h0000_1010);
        cycle("wrap0", 3'b001, 1'b1, 1'b1, 5'd9, 32'h0000_0099, 2'd0);
        cycle("wrap2", 3'b100, 1'b1, 1'b1, 5'd10, 32'h0000_1010, 2'd2);

        // Move rr_ptr to 1, then reset while a rd=5 write is offered
        req_valid = 3'b001;
        set_req(0, 5'd4, 32'h0000_0044);
        cycle("pre", 3'b001, 1'b0, 1'b1, 5'd4, 32'h0000_0044, 2'd0);

        rst = 1'b1;
        set_req(0, 5'd5, 32'h0000_0055);
        cycle("rstmid", 3'b000, 1'b0, 1'b0, 5'd0, 32'h0, 2'd0);

        // After reset rr_ptr is 0, so requester 0 wins over requester 1
        rst       = 1'b0;
        req_valid = 3'b011;
        set_req(1, 5'd6, 32'h0000_0066);
        cycle("post", 3'b001, 1'b1, 1'b1, 5'd5, 32'h0000_0055, 2'd0);
        cycle("post1", 3'b010, 1'b1, 1'b1, 5'd6, 32'h0000_0066, 2'd1);

        req_valid = 3'b000;
        cycle("drain", 3'b000, 1'b0, 1'b0, 5'd6, 32'h0000_0066, 2'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
